// File: rtl/nand_pkg.sv
// Shared definitions for the NAND page-read controller: command opcodes and
// the state encodings of the sequencer and of the per-byte latch engine.
package nand_pkg;

  localparam logic [7:0] NAND_CMD_READ1 = 8'h00;
  localparam logic [7:0] NAND_CMD_READ2 = 8'h30;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD1,
    ST_ADDR,
    ST_CMD2,
    ST_WB,
    ST_WAIT_RB,
    ST_RD_LOW,
    ST_RD_HIGH,
    ST_DONE,
    ST_ERR
  } rd_state_t;

  typedef enum logic [1:0] {
    LT_IDLE,
    LT_LOW,
    LT_HIGH
  } lat_state_t;

endpackage

// File: rtl/nand_latch_cycle.sv
// Drives one command or address latch on the NAND pins: CLE or ALE, IO and
// IO_OE are held for the whole latch while WEn is low tWP_CNT cycles and then
// high tWP_CNT cycles. i_start is accepted only when idle; o_done pulses for
// one cycle as the pins return to their idle levels.
module nand_latch_cycle
  import nand_pkg::*;
#(
  parameter int tWP_CNT = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       i_start,
  input  logic       i_is_cmd,
  input  logic [7:0] i_byte,
  output logic       o_cle,
  output logic       o_ale,
  output logic       o_wen,
  output logic       o_oe,
  output logic [7:0] o_io,
  output logic       o_done
);

  localparam int CW = (tWP_CNT > 1) ? $clog2(tWP_CNT) : 1;
  localparam logic [CW-1:0] WP_LAST = CW'(tWP_CNT - 1);

  lat_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_cle;
  logic          r_ale;
  logic          r_wen;
  logic          r_oe;
  logic [7:0]    r_io;
  logic          r_done;

  // Latch sequencer: WEn low half, WEn high half, then release the pins.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state <= LT_IDLE;
      r_cnt   <= '0;
      r_cle   <= 1'b0;
      r_ale   <= 1'b0;
      r_wen   <= 1'b1;
      r_oe    <= 1'b0;
      r_io    <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        LT_IDLE: begin
          if (i_start) begin
            r_cle   <= i_is_cmd;
            r_ale   <= ~i_is_cmd;
            r_io    <= i_byte;
            r_oe    <= 1'b1;
            r_wen   <= 1'b0;
            r_cnt   <= '0;
            r_state <= LT_LOW;
          end
        end
        LT_LOW: begin
          if (r_cnt == WP_LAST) begin
            r_wen   <= 1'b1;
            r_cnt   <= '0;
            r_state <= LT_HIGH;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        LT_HIGH: begin
          if (r_cnt == WP_LAST) begin
            r_cle   <= 1'b0;
            r_ale   <= 1'b0;
            r_oe    <= 1'b0;
            r_io    <= 8'h00;
            r_done  <= 1'b1;
            r_state <= LT_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= LT_IDLE;
      endcase
    end
  end

  assign o_cle  = r_cle;
  assign o_ale  = r_ale;
  assign o_wen  = r_wen;
  assign o_oe   = r_oe;
  assign o_io   = r_io;
  assign o_done = r_done;

endmodule

// File: rtl/nand_page_read_ctrl.sv
// NAND page read sequencer: 00h, ADDR_CYCLES address bytes (LSB first), 30h,
// tWB wait, R/B# wait with timeout, then LEN read strobes with a one-deep
// output register that applies backpressure to the read strobes.
module nand_page_read_ctrl
  import nand_pkg::*;
#(
  parameter int ADDR_CYCLES = 5,
  parameter int tWP_CNT     = 2,
  parameter int tREA_CNT    = 2,
  parameter int tWB_CNT     = 4,
  parameter int TIMEOUT_CNT = 65535
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Start,
  input  logic [63:0] ADDR,
  input  logic [15:0] LEN,
  output logic        Busy,
  output logic        Over,
  output logic        Err,
  output logic [7:0]  DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic        CLE,
  output logic        ALE,
  output logic        WEn,
  output logic        REn,
  output logic [7:0]  IO_OUT,
  output logic        IO_OE,
  input  logic [7:0]  IO_IN,
  input  logic        RB
);

  localparam int TW = $clog2(TIMEOUT_CNT + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CNT - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CNT);
  localparam logic [15:0]   WB_LAST   = 16'(tWB_CNT - 1);
  localparam logic [15:0]   REA_LAST  = 16'(tREA_CNT - 1);
  localparam logic [2:0]    ADDR_LAST = 3'(ADDR_CYCLES - 1);

  rd_state_t     r_state;
  logic [63:0]   r_addr;
  logic [15:0]   r_left;
  logic [2:0]    r_aidx;
  logic [15:0]   r_dly;
  logic [TW-1:0] r_wait;
  logic          r_lat_start;
  logic          r_lat_cmd;
  logic [7:0]    r_lat_byte;
  logic          r_busy;
  logic          r_over;
  logic          r_err;
  logic          r_ren;
  logic [7:0]    r_dout;
  logic          r_dvalid;
  logic          w_lat_done;

  // The latch engine is the only driver of CLE/ALE/WEn/IO; outside a latch
  // it holds those pins at their idle levels.
  nand_latch_cycle #(
    .tWP_CNT (tWP_CNT)
  ) u_latch (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .i_start  (r_lat_start),
    .i_is_cmd (r_lat_cmd),
    .i_byte   (r_lat_byte),
    .o_cle    (CLE),
    .o_ale    (ALE),
    .o_wen    (WEn),
    .o_oe     (IO_OE),
    .o_io     (IO_OUT),
    .o_done   (w_lat_done)
  );

  // Operation sequencer, wait/timeout counters, read strobe and output byte.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_left      <= '0;
      r_aidx      <= '0;
      r_dly       <= '0;
      r_wait      <= '0;
      r_lat_start <= 1'b0;
      r_lat_cmd   <= 1'b0;
      r_lat_byte  <= 8'h00;
      r_busy      <= 1'b0;
      r_over      <= 1'b0;
      r_err       <= 1'b0;
      r_ren       <= 1'b1;
      r_dout      <= 8'h00;
      r_dvalid    <= 1'b0;
    end else begin
      r_lat_start <= 1'b0;
      r_over      <= 1'b0;
      r_err       <= 1'b0;
      // Consumer handshake; a capture later in this block takes priority.
      if (r_dvalid && DOUT_READY) r_dvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_addr      <= ADDR;
            r_left      <= LEN;
            r_busy      <= 1'b1;
            r_lat_start <= 1'b1;
            r_lat_cmd   <= 1'b1;
            r_lat_byte  <= NAND_CMD_READ1;
            r_state     <= ST_CMD1;
          end
        end
        ST_CMD1: begin
          if (w_lat_done) begin
            r_lat_start <= 1'b1;
            r_lat_cmd   <= 1'b0;
            r_lat_byte  <= r_addr[7:0];
            r_addr      <= r_addr >> 8;
            r_aidx      <= '0;
            r_state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_lat_done) begin
            r_lat_start <= 1'b1;
            if (r_aidx == ADDR_LAST) begin
              r_lat_cmd  <= 1'b1;
              r_lat_byte <= NAND_CMD_READ2;
              r_state    <= ST_CMD2;
            end else begin
              r_lat_byte <= r_addr[7:0];
              r_addr     <= r_addr >> 8;
              r_aidx     <= r_aidx + 3'd1;
            end
          end
        end
        ST_CMD2: begin
          if (w_lat_done) begin
            r_dly   <= '0;
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          // R/B# is not trustworthy until tWB has elapsed after 30h.
          if (r_dly == WB_LAST) begin
            r_wait  <= '0;
            r_state <= ST_WAIT_RB;
          end else begin
            r_dly <= r_dly + 16'd1;
          end
        end
        ST_WAIT_RB: begin
          if (RB) begin
            if (r_left != 16'd0) begin
              r_ren   <= 1'b0;
              r_dly   <= '0;
              r_state <= ST_RD_LOW;
            end else begin
              r_over  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else if (r_wait == TO_LAST) begin
            r_over  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ST_ERR;
          end else if (r_wait != TO_MAX) begin
            r_wait <= r_wait + TW'(1);
          end
        end
        ST_RD_LOW: begin
          if (r_dly == REA_LAST) begin
            r_dout   <= IO_IN;
            r_dvalid <= 1'b1;
            r_ren    <= 1'b1;
            r_state  <= ST_RD_HIGH;
          end else begin
            r_dly <= r_dly + 16'd1;
          end
        end
        ST_RD_HIGH: begin
          // Only strobe again once the held byte is gone or leaving now.
          if (!r_dvalid || DOUT_READY) begin
            r_left <= r_left - 16'd1;
            if (r_left == 16'd1) begin
              r_over  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_ren   <= 1'b0;
              r_dly   <= '0;
              r_state <= ST_RD_LOW;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy       = r_busy;
  assign Over       = r_over;
  assign Err        = r_err;
  assign REn        = r_ren;
  assign DOUT       = r_dout;
  assign DOUT_VALID = r_dvalid;

endmodule
